// File: rtl/chacha_stream_ctrl.sv
// chacha_stream_ctrl
// Sequences a byte-serial ChaCha block core over one message: the first 64
// host bytes are forwarded to the core as its initial state, each following
// host byte is XORed with the next keystream byte, and leftover keystream is
// flushed so the core's byte pointer is block-aligned for the next message.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   start, msg_len    begin a message (IDLE only) / payload byte count
//   busy, done        not-IDLE flag / one-cycle completion pulse
//   in_data/valid/ready    host byte stream
//   out_data/valid/ready   result byte stream (out_data registered)
//   core_data_in, core_write        load path to the core
//   core_data_out, core_ready, core_read  keystream path from the core
module chacha_stream_ctrl #(
    parameter int unsigned LEN_W = 16,
    parameter int unsigned GUARD = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    output logic             busy,
    output logic             done,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       core_data_in,
    output logic             core_write,
    output logic             core_read,
    input  logic [7:0]       core_data_out,
    input  logic             core_ready
);

    localparam int unsigned GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_STREAM,
        ST_FLUSH,
        ST_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [5:0]       load_cnt_q, load_cnt_d;
    logic [GW-1:0]    guard_q, guard_d;
    logic [5:0]       byte_idx_q, byte_idx_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;

    logic             in_ready_c;
    logic             write_c;
    logic             read_c;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        load_cnt_d  = load_cnt_q;
        guard_d     = guard_q;
        byte_idx_d  = byte_idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        in_ready_c  = 1'b0;
        write_c     = 1'b0;
        read_c      = 1'b0;

        // Pending byte drains in any state; STREAM may reload it below.
        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    remaining_d = msg_len;
                    load_cnt_d  = '0;
                end
            end
            ST_LOAD: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    write_c    = 1'b1;
                    load_cnt_d = load_cnt_q + 6'd1;
                    if (load_cnt_q == 6'd63) begin
                        state_d = ST_WAIT;
                        guard_d = GW'(GUARD);
                    end
                end
            end
            ST_WAIT: begin
                // core_ready is not trusted until the guard has expired.
                if (guard_q != '0) begin
                    guard_d = guard_q - 1'b1;
                end else if (core_ready) begin
                    if (remaining_q == '0) begin
                        state_d = (byte_idx_q != '0) ? ST_FLUSH : ST_FIN;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                in_ready_c = core_ready & (~out_valid_q | out_ready);
                if (in_valid && in_ready_c) begin
                    read_c      = 1'b1;
                    out_data_d  = in_data ^ core_data_out;
                    out_valid_d = 1'b1;
                    byte_idx_d  = byte_idx_q + 6'd1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = (byte_idx_q == 6'd63) ? ST_FIN : ST_FLUSH;
                    end else if (byte_idx_q == 6'd63) begin
                        state_d = ST_WAIT;
                        guard_d = GW'(GUARD);
                    end
                end
            end
            ST_FLUSH: begin
                if (core_ready) begin
                    read_c     = 1'b1;
                    byte_idx_d = byte_idx_q + 6'd1;
                    if (byte_idx_q == 6'd63) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                if (!out_valid_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            load_cnt_q  <= '0;
            guard_q     <= '0;
            byte_idx_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            load_cnt_q  <= load_cnt_d;
            guard_q     <= guard_d;
            byte_idx_q  <= byte_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    // Strobes are masked during reset so an abort never touches the core.
    assign in_ready     = in_ready_c & rst_n;
    assign core_write   = write_c & rst_n;
    assign core_read    = read_c & rst_n;
    assign core_data_in = in_data;
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
module tb_chacha_stream_ctrl;

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned GUARD  = 2;
    localparam int          BUDGET = 4000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] msg_len;
    logic             busy;
    logic             done;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       core_data_in;
    logic             core_write;
    logic             core_read;
    logic [7:0]       core_data_out;
    logic             core_ready;

    always #5 clk = ~clk;

    chacha_stream_ctrl #(.LEN_W(LEN_W), .GUARD(GUARD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .msg_len(msg_len),
        .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .core_data_in(core_data_in), .core_write(core_write),
        .core_read(core_read), .core_data_out(core_data_out),
        .core_ready(core_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Keystream of message m is an arbitrary but fixed byte sequence.
    function automatic logic [7:0] ks(input int m, input int i);
        int v;
        v = i * 29 + m * 71 + (i / 64) * 113 + 7;
        v = v ^ (v >> 3);
        return v[7:0];
    endfunction

    // Core model: a keystream pointer advanced by every core_read.
    int msg_id = 0;
    int rd_ptr = 0;
    int stall  = 0;
    assign core_data_out = core_ready ? ks(msg_id, rd_ptr) : 8'hA5;

    logic [7:0] host_q[$];
    logic [7:0] exp_q[$];
    int  host_idx, writes, reads, outs, dones, guard_win;
    int  cr_pct, or_pct, iv_pct, hold_at, hold_cnt, bst_at, abort_at;
    bit  drop_mode, aborted, post_rst, prev_hold;
    logic [7:0] prev_data;

    task automatic drive(input int cn);
        rst_n   = !(cn == abort_at);
        start   = (cn == 0) || (cn == bst_at);
        msg_len = (cn == 0) ? msg_len : LEN_W'($urandom);
        in_valid = (host_idx < host_q.size()) && ($urandom_range(99) < iv_pct);
        in_data  = (host_idx < host_q.size()) ? host_q[host_idx] : 8'($urandom);
        if (stall > 0) begin
            stall--;
            core_ready = 1'b0;
        end else begin
            core_ready = ($urandom_range(99) < cr_pct);
        end
        if (hold_at >= 0 && outs == hold_at) begin
            hold_cnt = 5;
            hold_at  = -1;
        end
        if (hold_cnt > 0) begin
            hold_cnt--;
            out_ready = 1'b0;
        end else begin
            out_ready = ($urandom_range(99) < or_pct);
        end
    endtask

    task automatic cycle(input int c);
        logic w, r;
        w = 1'b0;
        r = 1'b0;
        @(negedge clk);
        if (!rst_n) begin
            post_rst = 1'b1;
        end else if (post_rst) begin
            check("rst_busy", busy, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_core_write", core_write, 0);
            check("rst_core_read", core_read, 0);
            check("rst_done", done, 0);
            post_rst  = 1'b0;
            aborted   = 1'b1;
            prev_hold = 1'b0;
        end else begin
            w = core_write;
            r = core_read;
            if (c == 0) check("idle_busy", busy, 0);
            if (w || r) check("wr_rd_excl", w & r, 0);
            if (!core_ready) check("rd_not_ready", r, 0);
            if (guard_win > 0) begin
                check("rd_in_guard", r, 0);
                guard_win--;
            end
            if (w) begin
                writes++;
                check("wr_data", core_data_in, host_q[host_idx]);
                if (writes == 64) guard_win = GUARD;
            end
            if (r) begin
                reads++;
                if (reads % 64 == 0) guard_win = GUARD;
            end
            if (in_valid && in_ready && host_idx < host_q.size()) host_idx++;
            if (out_valid && !out_ready) check("bp_in_ready", in_ready, 0);
            if (prev_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            prev_hold = out_valid & ~out_ready;
            prev_data = out_data;
            if (out_valid && out_ready) begin
                if (outs < exp_q.size())
                    check($sformatf("out[%0d]", outs), out_data, exp_q[outs]);
                else
                    check("out_overflow", outs, exp_q.size());
                outs++;
            end
            if (done) begin
                dones++;
                check("done_busy", busy, 0);
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            rd_ptr++;
            if (drop_mode && rd_ptr % 64 == 0) stall = 20;
        end
        if (aborted) rd_ptr = 0;
        drive(c + 1);
    endtask

    task automatic run_msg(input int len, input int pat, input int crp, input int orp,
                           input int ivp, input bit drop, input int hold,
                           input int bst, input int abrt);
        int c;
        int exp_reads;
        logic [7:0] b;
        msg_id++;
        host_q.delete();
        exp_q.delete();
        for (int i = 0; i < 64; i++) host_q.push_back(8'($urandom));
        for (int i = 0; i < len; i++) begin
            b = (pat == 0) ? 8'h00 : (pat == 1) ? 8'hFF : 8'($urandom);
            host_q.push_back(b);
            exp_q.push_back(b ^ ks(msg_id, i));
        end
        cr_pct = crp; or_pct = orp; iv_pct = ivp; drop_mode = drop;
        hold_at = hold; hold_cnt = 0; bst_at = bst; abort_at = abrt;
        host_idx = 0; writes = 0; reads = 0; outs = 0; dones = 0;
        guard_win = 0; rd_ptr = 0; stall = 0;
        aborted = 1'b0; post_rst = 1'b0; prev_hold = 1'b0;
        msg_len = LEN_W'(len);
        drive(0);
        c = 0;
        while (dones == 0 && !aborted && c < BUDGET) begin
            cycle(c);
            c++;
        end
        if (aborted) return;
        if (dones == 0) begin
            check("timeout_done", dones, 1);
            return;
        end
        repeat (3) begin
            cycle(c);
            c++;
        end
        exp_reads = (len == 0) ? 0 : ((len + 63) / 64) * 64;
        check($sformatf("writes(len=%0d)", len), writes, 64);
        check($sformatf("reads(len=%0d)", len), reads, exp_reads);
        check($sformatf("outs(len=%0d)", len), outs, len);
        check($sformatf("dones(len=%0d)", len), dones, 1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; msg_len = '0; in_data = '0;
        in_valid = 1'b0; out_ready = 1'b0; core_ready = 1'b0;
        abort_at = -1; bst_at = -1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_core_write", core_write, 0);
        check("reset_core_read", core_read, 0);
        @(posedge clk);
        #1;

        //       len  pat  cr%  or%  iv% drop hold bst abort
        run_msg(64,   0,   100, 100, 100, 0,  -1,  -1, -1);
        run_msg(10,   1,   100, 100, 100, 0,  -1,  -1, -1);
        run_msg(130,  2,   100, 100, 100, 1,  -1,  -1, -1);
        run_msg(100,  2,   100, 100, 100, 0,  20,  -1, -1);
        run_msg(20,   2,   80,  80,  80,  0,  -1,  30, -1);
        run_msg(0,    2,   100, 100, 100, 0,  -1,  40, -1);
        run_msg(100,  2,   100, 100, 100, 0,  -1,  -1, 80);
        run_msg(70,   2,   100, 100, 100, 0,  -1,  -1, -1);
        for (int k = 0; k < 6; k++) begin
            run_msg(int'($urandom_range(200, 1)), 2, int'($urandom_range(90, 40)),
                    int'($urandom_range(90, 40)), int'($urandom_range(100, 50)),
                    1'($urandom_range(1)), -1, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chacha_stream_ctrl.md
Name: chacha_stream_ctrl

Overview:
- Sequences the byte-serial ChaCha block core to encrypt or decrypt a byte stream of programmable length.
- Per message it does three things:
  - forwards the first 64 input bytes (initial state: constants, key, counter, nonce) to the core as writes;
  - XORs each following input byte with the next keystream byte read from the core;
  - flushes any unused keystream so the core's byte pointer is realigned for the next message.
- Sits between the host streaming interface and the block core.

Parameters:
- LEN_W, 16, width of the message length (payload bytes, excluding the 64 load bytes).
- GUARD, 2, cycles during which core_ready is ignored after a core phase change (after the last load write, or after the 64th read of a block).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a message; sampled only in IDLE
- msg_len  in  LEN_W  payload byte count, captured on an accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a message completes
- in_data  in  8  host byte
- in_valid  in  1  host byte valid
- in_ready  out  1  controller accepts the host byte
- out_data  out  8  ciphertext/plaintext byte, registered
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts out_data
- core_data_in  out  8  byte to core; equals in_data
- core_write  out  1  core load strobe
- core_read  out  1  consume the current keystream byte
- core_data_out  in  8  current keystream byte; valid while core_ready=1
- core_ready  in  1  core has keystream available

Behaviour:
- Reset values: state IDLE; busy, done, in_ready, out_valid, core_write, core_read = 0; out_data = 0; all counters = 0. Reset mid-message aborts immediately, drops any pending out byte, and issues no further core strobes.
- States: IDLE, LOAD, WAIT, STREAM, FLUSH, FIN.
- IDLE:
  - start=1 → LOAD; capture remaining=msg_len; load_cnt=0.
  - start while busy is ignored.
- LOAD:
  - in_ready=1.
  - Each handshake (in_valid & in_ready) asserts core_write combinationally with core_data_in=in_data, and increments load_cnt.
  - The 64th handshake → WAIT with guard=GUARD.
  - No output is produced.
- WAIT:
  - guard decrements to 0 while core_ready is ignored.
  - Then the state waits for core_ready=1:
    - remaining==0 → FLUSH if byte_idx≠0, else FIN;
    - otherwise → STREAM.
- STREAM:
  - in_ready = core_ready & (!out_valid | out_ready).
  - On handshake:
    - core_read=1 the same cycle;
    - out_data <= in_data ^ core_data_out; out_valid <= 1;
    - byte_idx (6-bit) increments; remaining decrements.
  - If out_ready=1 and no new byte is loaded, out_valid <= 0.
  - Transitions, checked in this order:
    - remaining hits 0 with byte_idx wrapped to 0 → FIN;
    - remaining hits 0 otherwise → FLUSH;
    - byte_idx wraps 63→0 with remaining>0 → WAIT with guard=GUARD, for the core's next-block computation.
- FLUSH:
  - core_read=1 every cycle while core_ready=1, with data discarded, until byte_idx wraps 63→0.
  - Then → FIN.
  - in_ready=0.
- FIN:
  - Holds until out_valid=0, i.e. the last byte is accepted.
  - Then pulses done for 1 cycle → IDLE.
- msg_len=0: LOAD → WAIT → FIN. Zero output bytes, no reads.
- core_write and core_read are never high in the same cycle.
- core_read is never asserted while core_ready=0 or during a guard.
- Throughput is 1 byte/cycle in STREAM with out_ready held high.

Test Plan:
- 64-byte load, msg_len=64, in_data=0x00, core keystream bytes k0..k63 → out bytes equal k0..k63; exactly 64 core_write and 64 core_read strobes; FLUSH skipped; done pulses once; busy falls the same cycle.
- msg_len=10, in_data=0xFF → out_data = ~k0..~k9; FLUSH issues exactly 54 core_read strobes; done after the flush completes.
- msg_len=130 with core_ready dropping for 20 cycles after byte 64 and after byte 128 → no core_read during the low intervals or guard windows; 130 outputs in order; 62-byte flush.
- out_ready held 0 for 5 cycles mid-stream → in_ready=0, core_read=0, out_data held stable; resumes without loss or duplication.
- start pulsed while busy → ignored, msg_len not recaptured. msg_len=0 → 64 writes, 0 reads, done pulse.
- rst_n=0 mid-STREAM → next cycle: IDLE, out_valid=0, busy=0, no strobes; a new start then loads cleanly.
